// File: rtl/ser_pkg.sv
// Shared types and constants for the pattern serializer.
// Optional feature macro: SER_PARITY_EN (appends one even-parity bit per frame).
package ser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  localparam int DEFAULT_WIDTH = 8;

`ifdef SER_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  localparam int FRAME_LEN = DEFAULT_WIDTH + PARITY_BITS;

  function automatic int frame_len(input int width);
    return width + PARITY_BITS;
  endfunction

endpackage

// File: rtl/pattern_serializer.sv
// MSB-first parallel-to-serial transmitter with gapless back-to-back frames.
// Optional feature macro: SER_PARITY_EN (even-parity bit after bit 0).
module pattern_serializer
  import ser_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             out,
  output logic             out_valid,
  output logic             frame_start,
  output logic             frame_last
);

  localparam int FL = frame_len(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FL - 1);

  ser_state_e       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             frame_last_q, frame_last_d;
  logic             accept;
`ifdef SER_PARITY_EN
  logic             parity_q, parity_d;
`endif

  // Handshake: a word transfers at a rising edge where load_valid && load_ready.
  // load_ready depends only on state/counter, never on load_valid; it is high in
  // IDLE and during the frame_last cycle so the next frame follows with no gap.
  assign load_ready = (state_q == IDLE) || (cnt_q == LAST_IDX);
  assign accept     = load_valid && load_ready;

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    cnt_d         = cnt_q;
    out_d         = 1'b0;
    out_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    frame_last_d  = 1'b0;
`ifdef SER_PARITY_EN
    parity_d      = parity_q;
`endif
    if (accept) begin
      state_d       = SHIFT;
      shift_d       = {load_data[WIDTH-2:0], 1'b0};
      cnt_d         = '0;
      out_d         = load_data[WIDTH-1];
      out_valid_d   = 1'b1;
      frame_start_d = 1'b1;
`ifdef SER_PARITY_EN
      parity_d      = ^load_data;
`endif
    end else if (state_q == SHIFT) begin
      if (cnt_q == LAST_IDX) begin
        state_d = IDLE;
      end else begin
        cnt_d        = cnt_q + CNT_W'(1);
        out_d        = shift_q[WIDTH-1];
        shift_d      = shift_q << 1;
        out_valid_d  = 1'b1;
        frame_last_d = (cnt_d == LAST_IDX);
`ifdef SER_PARITY_EN
        // Data bits are exhausted; the parity cycle uses the captured parity.
        if (cnt_d == CNT_W'(WIDTH)) out_d = parity_q;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      cnt_q         <= '0;
      out_q         <= 1'b0;
      out_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_last_q  <= 1'b0;
`ifdef SER_PARITY_EN
      parity_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      cnt_q         <= cnt_d;
      out_q         <= out_d;
      out_valid_q   <= out_valid_d;
      frame_start_q <= frame_start_d;
      frame_last_q  <= frame_last_d;
`ifdef SER_PARITY_EN
      parity_q      <= parity_d;
`endif
    end
  end

  assign out         = out_q;
  assign out_valid   = out_valid_q;
  assign frame_start = frame_start_q;
  assign frame_last  = frame_last_q;

endmodule

// File: tb/tb_pattern_serializer.sv
// Self-checking bench for pattern_serializer: bit scoreboard, frame collector,
// and a small 101 detector fed from the serial line.
module tb_pattern_serializer;
  import ser_pkg::*;

  localparam int W  = 8;
  localparam int FL = frame_len(W);

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         load_valid = 1'b0;
  logic [W-1:0] load_data = '0;
  logic         load_ready, out, out_valid, frame_start, frame_last;

  // clock / reset block
  always #5 clk = ~clk;

  pattern_serializer #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_ready  (load_ready),
    .out         (out),
    .out_valid   (out_valid),
    .frame_start (frame_start),
    .frame_last  (frame_last)
  );

  typedef struct packed {
    logic b;
    logic start;
    logic last;
  } exp_bit_t;

  exp_bit_t      sb_q[$];
  logic [FL-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_pass = 0;
  int            run_len = 0;
  int            max_run = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  // serial collector + per-bit scoreboard
  logic [FL-1:0] acc = '0;
  always @(negedge clk) begin
    exp_bit_t e;
    if (rst && out_valid) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
      if (sb_q.size() == 0) begin
        check("unexpected_bit", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("bit", {out, frame_start, frame_last}, e);
      end
      acc = frame_start ? FL'(out) : {acc[FL-2:0], out};
      if (frame_last) begin
        if (exp_q.size() == 0) check("unexpected_frame", 32'd1, 32'd0);
        else check("frame", acc, exp_q.pop_front());
      end
    end else begin
      run_len = 0;
      if (rst) check("idle_outputs", {out, frame_start, frame_last}, 32'd0);
    end
  end

  // 101 detector model consuming the serial line
  logic [1:0] det_hist;
  logic       det_q;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      det_hist <= 2'b00;
      det_q    <= 1'b0;
    end else begin
      det_q    <= (det_hist == 2'b10) && out;
      det_hist <= {det_hist[0], out};
    end
  end

  // driver: hold the word until accepted, then push its expected bits
  task automatic send_word(input logic [W-1:0] d, input logic p);
    int waited;
    logic [FL-1:0] f;
    @(negedge clk);
    load_valid = 1'b1;
    load_data  = d;
    #1;
    waited = 0;
    while (!load_ready && waited < 100) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!load_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      load_valid = 1'b0;
    end else begin
      for (int i = 0; i < W; i++)
        sb_q.push_back(exp_bit_t'({d[W-1-i], 1'(i == 0), 1'(i == FL-1)}));
`ifdef SER_PARITY_EN
      sb_q.push_back(exp_bit_t'({p, 1'b0, 1'b1}));
      f = {d, p};
`else
      f = d;
`endif
      exp_q.push_back(f);
      @(posedge clk);
      #1;
      load_valid = 1'b0;
      load_data  = W'($urandom);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while ((sb_q.size() != 0 || out_valid) && n < 100);
    check("drain", {31'd0, (sb_q.size() == 0) && !out_valid}, 32'd1);
    check("ready_idle", {31'd0, load_ready}, 32'd1);
  endtask

  typedef struct {
    logic [W-1:0] data;
    logic         parity;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int pulses;
    int pulse_at;
    logic [W-1:0] r;

    vecs[0] = '{8'hA5, 1'b0};
    vecs[1] = '{8'h81, 1'b0};
    vecs[2] = '{8'h3C, 1'b0};
    vecs[3] = '{8'h07, 1'b1};
    vecs[4] = '{8'h03, 1'b0};
    vecs[5] = '{8'h5A, 1'b0};
    vecs[6] = '{8'h01, 1'b1};
    vecs[7] = '{8'h80, 1'b1};
    vecs[8] = '{8'hF0, 1'b0};
    vecs[9] = '{8'hC3, 1'b0};

    // reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_out", {31'd0, out}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_frame_start", {31'd0, frame_start}, 32'd0);
    check("rst_frame_last", {31'd0, frame_last}, 32'd0);
    check("rst_load_ready", {31'd0, load_ready}, 32'd1);
    rst = 1'b1;

    // table-driven single frames
    foreach (vecs[i]) begin
      send_word(vecs[i].data, vecs[i].parity);
      wait_idle();
      check("post_frame_out_valid", {31'd0, out_valid}, 32'd0);
    end

    // back-to-back: 8'hFF then 8'h00 held valid until accepted
    max_run = 0;
    send_word(8'hFF, 1'b0);
    send_word(8'h00, 1'b0);
    wait_idle();
    check("gapless_run", max_run, 2 * FL);

    // load_valid while busy is ignored
    send_word(8'h5A, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        load_valid = 1'b1;
        load_data  = 8'h3C;
        #1;
        check("busy_ready", {31'd0, load_ready}, 32'd0);
      end
    end
    @(negedge clk);
    load_valid = 1'b0;
    wait_idle();
    check("no_extra_frame", exp_q.size(), 32'd0);

    // asynchronous reset in the middle of a frame
    send_word(8'hC3, 1'b0);
    repeat (4) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("abort_out", {31'd0, out}, 32'd0);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_frame_start", {31'd0, frame_start}, 32'd0);
    check("abort_frame_last", {31'd0, frame_last}, 32'd0);
    check("abort_load_ready", {31'd0, load_ready}, 32'd1);
    sb_q.delete();
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    send_word(8'h81, 1'b0);
    wait_idle();

    // loopback into the 101 detector
    repeat (3) @(negedge clk);
    send_word(8'h28, 1'b0);
    pulses   = 0;
    pulse_at = 0;
    for (int k = 1; k <= FL + 2; k++) begin
      @(negedge clk);
      if (det_q) begin
        pulses++;
        pulse_at = k;
      end
    end
    check("det_pulses", pulses, 32'd1);
    check("det_pulse_cycle", pulse_at, 32'd6);
    wait_idle();

    // random back-to-back words
    max_run = 0;
    for (int i = 0; i < 6; i++) begin
      r = W'($urandom_range(0, (1 << W) - 1));
      send_word(r, ^r);
    end
    wait_idle();
    check("random_gapless_run", max_run, 6 * FL);

    check("final_bits_empty", sb_q.size(), 32'd0);
    check("final_frames_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, required finished");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1);
  end

endmodule
